// File: rtl/state_time_setting.sv
// Time-setting state of the game-clock FSM: edits a BCD mm:ss start value and commits it for the countdown.
// Build option: define AUTO_REPEAT_EN for tick-paced auto-repeat of held inc/dec.
module state_time_setting #(
   parameter logic [2:0]  STATE_ID      = 3'd1,
   parameter logic [15:0] DEFAULT_VALUE = 16'h0500,
   parameter int unsigned REPEAT_DELAY  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic [2:0]  current_state,
   input  logic        btn_next,
   input  logic        btn_inc,
   input  logic        btn_dec,
   input  logic        btn_confirm,
   output logic [15:0] digits_out,
   output logic [3:0]  blank_mask,
   output logic [1:0]  cursor,
   output logic [15:0] value_out,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

   state_t      state_reg, state_next;
   logic [15:0] edit_reg, edit_next;
   logic [15:0] value_reg, value_next;
   logic [15:0] digits_reg, digits_next;
   logic [3:0]  blank_reg, blank_next;
   logic [1:0]  cursor_reg, cursor_next;
   logic        phase_reg, phase_next;
   logic        done_reg, done_next;
   logic [3:0]  hist_reg;

   logic [3:0]  btn_now, btn_rise;
   logic        active;
   logic [15:0] edit_up, edit_dn;
   logic        repeat_fire, repeat_up;

   // bit order {confirm, dec, inc, next}
   assign btn_now  = {btn_confirm, btn_dec, btn_inc, btn_next};
   assign btn_rise = btn_now & ~hist_reg;
   assign active   = (current_state == STATE_ID);

   // Per-digit wrap-around increment/decrement; sec1 tops out at 5, all others at 9.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         localparam logic [3:0] DMAX = (gi == 1) ? 4'd5 : 4'd9;
         logic [3:0] d;
         assign d = edit_reg[gi*4 +: 4];
         assign edit_up[gi*4 +: 4] = (d >= DMAX) ? 4'd0 : d + 4'd1;
         assign edit_dn[gi*4 +: 4] = (d == 4'd0) ? DMAX : d - 4'd1;
      end
   endgenerate

   function automatic logic [15:0] put_digit(input logic [15:0] base,
                                             input logic [15:0] src,
                                             input logic [1:0]  sel);
      logic [15:0] r;
      r = base;
      r[sel*4 +: 4] = src[sel*4 +: 4];
      return r;
   endfunction

`ifdef AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_DELAY + 2);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_DELAY);

   logic [RW-1:0] rpt_reg, rpt_next;
   logic          held_inc, held_dec, held_one, any_rise;

   assign held_inc    = btn_inc & hist_reg[1];
   assign held_dec    = btn_dec & hist_reg[2];
   assign held_one    = held_inc ^ held_dec;
   assign any_rise    = |btn_rise;
   assign repeat_up   = held_inc;
   assign repeat_fire = (state_reg == EDIT) && active && held_one && tick &&
                        !any_rise && (rpt_reg == RPT_LAST);

   // Counts ticks of a continuous hold; saturates at the delay, after which every tick repeats.
   always_comb begin
      rpt_next = rpt_reg;
      if (state_reg != EDIT || !active || !held_one || btn_rise[3] || btn_rise[0])
         rpt_next = '0;
      else if (tick && !any_rise && rpt_reg != RPT_LAST)
         rpt_next = rpt_reg + RW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         rpt_reg <= '0;
      else
         rpt_reg <= rpt_next;
   end
`else
   localparam int unsigned unused_repeat_delay = REPEAT_DELAY;
   assign repeat_fire = 1'b0;
   assign repeat_up   = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      edit_next   = edit_reg;
      value_next  = value_reg;
      cursor_next = cursor_reg;
      phase_next  = phase_reg;
      done_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (active) begin
               state_next  = EDIT;
               edit_next   = value_reg;
               cursor_next = 2'd3;
               phase_next  = 1'b0;
            end
         end
         EDIT: begin
            if (!active) begin
               state_next = IDLE;
               phase_next = 1'b0;
            end else if (btn_rise[3]) begin
               // An all-zero time would end the game immediately, so it is never committed.
               if (edit_reg != 16'h0000) begin
                  state_next = COMMIT;
                  value_next = edit_reg;
                  done_next  = 1'b1;
                  phase_next = 1'b0;
               end
            end else if (btn_rise[0]) begin
               cursor_next = cursor_reg - 2'd1;
               phase_next  = 1'b0;
            end else if (btn_rise[1] ^ btn_rise[2]) begin
               edit_next  = put_digit(edit_reg, btn_rise[1] ? edit_up : edit_dn, cursor_reg);
               phase_next = 1'b0;
            end else if (repeat_fire) begin
               edit_next  = put_digit(edit_reg, repeat_up ? edit_up : edit_dn, cursor_reg);
               phase_next = 1'b0;
            end else if (tick) begin
               phase_next = ~phase_reg;
            end
         end
         COMMIT: begin
            state_next = active ? EDIT : IDLE;
            phase_next = 1'b0;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      digits_next = (state_next == IDLE) ? value_next : edit_next;
      blank_next  = (state_next != IDLE && phase_next) ? (4'b0001 << cursor_next) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         edit_reg   <= DEFAULT_VALUE;
         value_reg  <= DEFAULT_VALUE;
         digits_reg <= DEFAULT_VALUE;
         blank_reg  <= 4'b0000;
         cursor_reg <= 2'd3;
         phase_reg  <= 1'b0;
         done_reg   <= 1'b0;
         hist_reg   <= 4'b0000;
      end else begin
         state_reg  <= state_next;
         edit_reg   <= edit_next;
         value_reg  <= value_next;
         digits_reg <= digits_next;
         blank_reg  <= blank_next;
         cursor_reg <= cursor_next;
         phase_reg  <= phase_next;
         done_reg   <= done_next;
         hist_reg   <= btn_now;
      end
   end

   assign digits_out = digits_reg;
   assign blank_mask = blank_reg;
   assign cursor     = cursor_reg;
   assign value_out  = value_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_state_time_setting.sv
// Bench for state_time_setting: directed vector table, hand-written corner sequences, and random stimulus vs a digit-level model.
module tb_state_time_setting;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic [2:0]  current_state = 3'd0;
   logic        btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_confirm = 1'b0;
   logic [15:0] digits_out, value_out;
   logic [3:0]  blank_mask;
   logic [1:0]  cursor;
   logic        done;

   always #5 clk = ~clk;

   state_time_setting dut (
      .clk(clk), .reset(reset), .tick(tick), .current_state(current_state),
      .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_confirm(btn_confirm),
      .digits_out(digits_out), .blank_mask(blank_mask), .cursor(cursor),
      .value_out(value_out), .done(done)
   );

   int checks = 0;
   int errors = 0;

   // Model: digits held as integers, index 0=sec0 .. 3=min1; mode 0=idle, 1=editing, 2=just committed.
   int       mv[4], me[4];
   int       mcur, mmode, mrpt;
   bit       mph, mdone;
   bit [3:0] mh;

   localparam int DELAY = 4;

   function automatic int dmax(input int k);
      return (k == 1) ? 5 : 9;
   endfunction

   function automatic logic [15:0] pack4(input int d0, input int d1, input int d2, input int d3);
      return {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
   endfunction

   task automatic model_reset();
      mv = '{0, 0, 5, 0};
      me = mv;
      mcur = 3; mmode = 0; mrpt = 0; mph = 0; mdone = 0; mh = '0;
   endtask

   task automatic bump(input bit up);
      int m;
      m = dmax(mcur) + 1;
      me[mcur] = up ? (me[mcur] + 1) % m : (me[mcur] + m - 1) % m;
   endtask

   task automatic model_step(input logic [2:0] st, input logic [3:0] b, input logic t);
      bit en, ei, ed, ec, hi, hd, act;
      en = b[0] & ~mh[0]; ei = b[1] & ~mh[1]; ed = b[2] & ~mh[2]; ec = b[3] & ~mh[3];
      hi = b[1] & mh[1];  hd = b[2] & mh[2];
      act = (st == 3'd1);
      mdone = 0;
      if (mmode == 0) begin
         if (act) begin mmode = 1; me = mv; mcur = 3; mph = 0; end
         mrpt = 0;
      end else if (mmode == 2) begin
         mmode = act ? 1 : 0; mph = 0; mrpt = 0;
      end else if (!act) begin
         mmode = 0; mph = 0; mrpt = 0;
      end else begin
         if (ec) begin
            if (pack4(me[0], me[1], me[2], me[3]) != 16'h0000) begin
               mv = me; mmode = 2; mdone = 1; mph = 0;
            end
         end else if (en) begin
            mcur = (mcur + 3) % 4; mph = 0;
         end else if (ei ^ ed) begin
            bump(ei); mph = 0;
`ifdef AUTO_REPEAT_EN
         end else if (t && (hi ^ hd) && !(ei | ed) && mrpt == DELAY) begin
            bump(hi); mph = 0;
`endif
         end else if (t) begin
            mph = ~mph;
         end
`ifdef AUTO_REPEAT_EN
         if (ec || en || !(hi ^ hd)) mrpt = 0;
         else if (t && !(ei | ed) && mrpt < DELAY) mrpt++;
`endif
      end
      mh = b;
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // One clock: drive on the falling edge, step the model, compare shortly after the rising edge.
   task automatic cyc(input logic [2:0] st, input logic [3:0] b, input logic t);
      logic [15:0] ev, ee;
      logic [3:0]  eb;
      @(negedge clk);
      current_state = st;
      btn_next = b[0]; btn_inc = b[1]; btn_dec = b[2]; btn_confirm = b[3];
      tick = t;
      model_step(st, b, t);
      @(posedge clk);
      #1;
      ev = pack4(mv[0], mv[1], mv[2], mv[3]);
      ee = pack4(me[0], me[1], me[2], me[3]);
      eb = (mmode != 0 && mph) ? (4'b0001 << mcur) : 4'b0000;
      $display("cyc st=%0d btn=%b tick=%b -> digits=%h blank=%b cursor=%0d value=%h done=%b",
               st, b, t, digits_out, blank_mask, cursor, value_out, done);
      chk("model digits", digits_out, (mmode == 0) ? ev : ee);
      chk("model blank", 16'(blank_mask), 16'(eb));
      chk("model cursor", 16'(cursor), 16'(mcur));
      chk("model value", value_out, ev);
      chk("model done", 16'(done), 16'(mdone));
   endtask

   task automatic press(input logic [3:0] b);
      cyc(3'd1, b, 1'b0);
      cyc(3'd1, 4'b0000, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; current_state = 3'd0; tick = 1'b0;
      btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_confirm = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      model_reset();
      $display("reset -> digits=%h blank=%b cursor=%0d value=%h done=%b",
               digits_out, blank_mask, cursor, value_out, done);
      chk("reset value", value_out, 16'h0500);
      chk("reset digits", digits_out, 16'h0500);
      chk("reset blank", 16'(blank_mask), 16'h0000);
      chk("reset done", 16'(done), 16'h0000);
      chk("reset cursor", 16'(cursor), 16'h0003);
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  st;
      logic [3:0]  btn;     // {confirm, dec, inc, next}
      logic        tk;
      logic [15:0] e_dig;
      logic [1:0]  e_cur;
      logic [15:0] e_val;
      logic        e_done;
   } vec_t;

   localparam logic [3:0] N = 4'b0001, I = 4'b0010, D = 4'b0100, C = 4'b1000, Z = 4'b0000;

   vec_t vt[$];
   logic [3:0] rb;
   logic [2:0] rst;

   task automatic add(input logic [3:0] b, input logic [15:0] dig, input logic [1:0] cur);
      vt.push_back('{3'd1, b, 1'b0, dig, cur, 16'h0500, 1'b0});
   endtask

   initial begin
      add(Z, 16'h0500, 2'd3); add(N, 16'h0500, 2'd2); add(Z, 16'h0500, 2'd2);
      add(N, 16'h0500, 2'd1); add(Z, 16'h0500, 2'd1);
      add(I, 16'h0510, 2'd1); add(Z, 16'h0510, 2'd1); add(I, 16'h0520, 2'd1); add(Z, 16'h0520, 2'd1);
      add(I, 16'h0530, 2'd1); add(Z, 16'h0530, 2'd1); add(I, 16'h0540, 2'd1); add(Z, 16'h0540, 2'd1);
      add(I, 16'h0550, 2'd1); add(Z, 16'h0550, 2'd1); add(I, 16'h0500, 2'd1); add(Z, 16'h0500, 2'd1);
      add(N, 16'h0500, 2'd0); add(Z, 16'h0500, 2'd0); add(N, 16'h0500, 2'd3); add(Z, 16'h0500, 2'd3);
      add(D, 16'h9500, 2'd3); add(Z, 16'h9500, 2'd3); add(I | D, 16'h9500, 2'd3); add(Z, 16'h9500, 2'd3);

      do_reset();
      foreach (vt[k]) begin
         cyc(vt[k].st, vt[k].btn, vt[k].tk);
         chk($sformatf("vec%0d digits", k), digits_out, vt[k].e_dig);
         chk($sformatf("vec%0d cursor", k), 16'(cursor), 16'(vt[k].e_cur));
         chk($sformatf("vec%0d value", k), value_out, vt[k].e_val);
         chk($sformatf("vec%0d done", k), 16'(done), 16'(vt[k].e_done));
      end

      // Zero-time confirm is ignored, then a real commit pulses done once.
      press(I); chk("min1 wrap up", digits_out, 16'h0500);
      press(N); repeat (5) press(D); chk("edit zero", digits_out, 16'h0000);
      cyc(3'd1, C, 1'b0);
      chk("zero confirm done", 16'(done), 16'h0000);
      chk("zero confirm value", value_out, 16'h0500);
      cyc(3'd1, Z, 1'b0);
      repeat (2) press(I); press(N); repeat (3) press(I); press(N); press(N); press(I);
      chk("edit 1230", digits_out, 16'h1230);
      cyc(3'd1, C, 1'b0);
      chk("commit done", 16'(done), 16'h0001);
      chk("commit value", value_out, 16'h1230);
      cyc(3'd1, Z, 1'b0);
      chk("done one cycle", 16'(done), 16'h0000);
      cyc(3'd0, Z, 1'b0);
      chk("idle shows value", digits_out, 16'h1230);
      cyc(3'd1, Z, 1'b0);
      chk("reenter digits", digits_out, 16'h1230);

      // Leaving without confirm discards edits; a held button across entry does nothing.
      repeat (3) press(I); press(N); repeat (2) press(I); press(N); repeat (3) press(I);
      chk("edit 4400", digits_out, 16'h4400);
      cyc(3'd0, Z, 1'b0);
      chk("discard value", value_out, 16'h1230);
      chk("discard digits", digits_out, 16'h1230);
      cyc(3'd0, I, 1'b0); cyc(3'd1, I, 1'b0); cyc(3'd1, I, 1'b0);
      chk("held inc on entry", digits_out, 16'h1230);
      cyc(3'd1, Z, 1'b0);

      // Blink phase and event-beats-tick.
      cyc(3'd1, Z, 1'b1); chk("blink on", 16'(blank_mask), 16'h0008);
      cyc(3'd1, Z, 1'b0); chk("blink hold", 16'(blank_mask), 16'h0008);
      cyc(3'd1, Z, 1'b1); chk("blink off", 16'(blank_mask), 16'h0000);
      cyc(3'd1, Z, 1'b1); chk("blink on again", 16'(blank_mask), 16'h0008);
      cyc(3'd1, N, 1'b1);
      chk("next on tick cursor", 16'(cursor), 16'h0002);
      chk("next on tick blank", 16'(blank_mask), 16'h0000);
      cyc(3'd1, Z, 1'b0);

      // Hold inc for 8 ticks on sec0.
      press(N); press(N);
      cyc(3'd1, I, 1'b0);
      repeat (8) begin cyc(3'd1, I, 1'b1); cyc(3'd1, I, 1'b0); end
`ifdef AUTO_REPEAT_EN
      chk("hold inc 8 ticks", digits_out, 16'h1235);
`else
      chk("hold inc 8 ticks", digits_out, 16'h1231);
`endif
      cyc(3'd1, Z, 1'b0);

      // Reset while in the commit cycle.
      cyc(3'd1, C, 1'b0);
      chk("precommit done", 16'(done), 16'h0001);
      do_reset();

      // Random traffic against the model.
      rb = '0;
      repeat (800) begin
         rst = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
         for (int k = 0; k < 3; k++)
            if ($urandom_range(0, 3) == 0) rb[k] = ~rb[k];
         if ($urandom_range(0, 11) == 0) rb[3] = ~rb[3];
         cyc(rst, rb, 1'($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
